// File: rtl/prog_delay_line.sv
// Runtime-programmable delay line with per-stage valid tracking, flush, stall,
// an in-flight item counter and rejection of reconfiguration while busy.
module prog_delay_line #(
  parameter int WIDTH     = 32,
  parameter int MAX_DEPTH = 16,
  parameter int DLY_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             dly_load,
  input  logic [DLY_W-1:0] dly_sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [DLY_W-1:0] dly_cur,
  output logic             dly_err,
  output logic             busy,
  output logic [DLY_W-1:0] count
);

  localparam logic [DLY_W-1:0] DLY_MAX = DLY_W'(MAX_DEPTH);

  logic [WIDTH-1:0]     d_q [MAX_DEPTH];
  logic [MAX_DEPTH-1:0] v_q, v_d;
  logic [DLY_W-1:0]     dly_q, dly_d;
  logic [DLY_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic                 advance;
  logic                 tap_v;
  logic [WIDTH-1:0]     tap_d;
  logic                 in_acc;
  logic                 sel_ok;
  logic                 load_acc;

  assign advance = ~stall & ~flush;
  assign in_acc  = in_valid & ~stall;

  // Output tap: stage dly_cur-1, selected by comparison so no index truncation
  always_comb begin
    tap_d = '0;
    tap_v = 1'b0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (dly_q == DLY_W'(i + 1)) begin
        tap_d = d_q[i];
        tap_v = v_q[i];
      end
    end
  end

  assign out_valid = tap_v & advance;
  assign out_data  = tap_d;
  assign busy      = |v_q;
  assign dly_cur   = dly_q;
  assign dly_err   = err_q;
  assign count     = cnt_q;

  // Valid bits beyond the active tap are masked so they never reach busy/count
  always_comb begin
    v_d = v_q;
    if (flush) begin
      v_d = '0;
    end else if (!stall) begin
      v_d[0] = in_valid;
      for (int i = 1; i < MAX_DEPTH; i++) begin
        v_d[i] = v_q[i-1] & (DLY_W'(i) < dly_q);
      end
    end
  end

  always_comb begin
    if (flush) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DLY_W'(in_acc) - DLY_W'(out_valid);
    end
  end

  // Reconfiguration only while empty, so no item ever sees two different delays
  assign sel_ok   = (dly_sel != '0) && (dly_sel <= DLY_MAX);
  assign load_acc = dly_load & ~busy & sel_ok;
  assign dly_d    = load_acc ? dly_sel : dly_q;
  assign err_d    = dly_load & ~load_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      dly_q <= DLY_MAX;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      v_q   <= v_d;
      dly_q <= dly_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Data shifts on every advance regardless of valid
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_DEPTH; i++) begin
        d_q[i] <= '0;
      end
    end else if (advance) begin
      d_q[0] <= in_data;
      for (int i = 1; i < MAX_DEPTH; i++) begin
        d_q[i] <= d_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_prog_delay_line.sv
// Bench for prog_delay_line: directed scenarios followed by random traffic,
// compared against an age-based item model and an input-word history.
module tb_prog_delay_line;

  localparam int WIDTH     = 32;
  localparam int MAX_DEPTH = 16;
  localparam int DLY_W     = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             stall = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             dly_load = 1'b0;
  logic [DLY_W-1:0] dly_sel = '0;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [DLY_W-1:0] dly_cur;
  logic             dly_err;
  logic             busy;
  logic [DLY_W-1:0] count;

  prog_delay_line #(.WIDTH(WIDTH), .MAX_DEPTH(MAX_DEPTH), .DLY_W(DLY_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data),
    .dly_load(dly_load), .dly_sel(dly_sel),
    .out_valid(out_valid), .out_data(out_data),
    .dly_cur(dly_cur), .dly_err(dly_err),
    .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: each in-flight item carries its age in advances since
  // capture; hist holds the words taken on every advance, newest first.
  int          age_q[$];
  logic [31:0] hist[$];
  int          m_dly;
  logic        m_err;
  bit          known = 0;
  int          emitted = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    age_q.delete();
    hist.delete();
    repeat (MAX_DEPTH) hist.push_back(32'h0);
    m_dly = MAX_DEPTH;
    m_err = 1'b0;
    known = 1;
  endtask

  task automatic step(input logic r, input logic s, input logic f, input logic v,
                      input logic [31:0] dat, input logic ld, input logic [4:0] sel);
    logic exp_ov;
    bit   acc;
    @(negedge clk);
    rst = r; stall = s; flush = f; in_valid = v; in_data = dat;
    dly_load = ld; dly_sel = sel;
    #1;
    if (known) begin
      exp_ov = (age_q.size() > 0 && age_q[0] == m_dly - 1) && !s && !f;
      chk("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
      chk("out_data",  out_data, hist[m_dly-1]);
      chk("dly_cur",   {27'b0, dly_cur}, 32'(m_dly));
      chk("dly_err",   {31'b0, dly_err}, {31'b0, m_err});
      chk("busy",      {31'b0, busy}, {31'b0, age_q.size() > 0});
      chk("count",     {27'b0, count}, 32'(age_q.size()));
      if (exp_ov) emitted++;
    end
    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (known) begin
      acc = ld && age_q.size() == 0 && sel >= 1 && sel <= MAX_DEPTH;
      if (f) begin
        age_q.delete();
      end else if (!s) begin
        if (age_q.size() > 0 && age_q[0] == m_dly - 1) void'(age_q.pop_front());
        foreach (age_q[k]) age_q[k]++;
        if (v) age_q.push_back(0);
        hist.push_front(dat);
        void'(hist.pop_back());
      end
      m_err = ld && !acc;
      if (acc) m_dly = int'(sel);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, $urandom, 0, 0);
  endtask

  task automatic load(input logic [4:0] sel);
    step(0, 0, 0, 0, $urandom, 1, sel);
  endtask

  initial begin
    int em0;
    logic s, f, v, ld, r;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(2);
    chk("reset_dly_cur", {27'b0, dly_cur}, 32'd16);

    // Default delay of 16 with three back-to-back items
    em0 = emitted;
    step(0, 0, 0, 1, 32'hA5A50001, 0, 0);
    step(0, 0, 0, 1, 32'hA5A50002, 0, 0);
    step(0, 0, 0, 1, 32'hA5A50003, 0, 0);
    idle(20);
    chk("default_emitted", 32'(emitted - em0), 32'd3);

    // Delay 3
    load(5'd3);
    idle(1);
    chk("dly3_cur", {27'b0, dly_cur}, 32'd3);
    step(0, 0, 0, 1, 32'h11, 0, 0);
    idle(5);

    // Delay 4 with a two-cycle stall in flight
    load(5'd4);
    em0 = emitted;
    step(0, 0, 0, 1, 32'h22, 0, 0);
    idle(1);
    step(0, 1, 0, 0, $urandom, 0, 0);
    step(0, 1, 0, 0, $urandom, 0, 0);
    idle(6);
    chk("stall_emitted_once", 32'(emitted - em0), 32'd1);

    // Rejections: busy, zero, too large
    step(0, 0, 0, 1, 32'h44, 0, 0);
    load(5'd5);
    idle(5);
    chk("busy_reject_dly", {27'b0, dly_cur}, 32'd4);
    load(5'd0);
    idle(1);
    load(5'd17);
    idle(2);

    // Flush with a coincident input
    em0 = emitted;
    step(0, 0, 0, 1, 32'h31, 0, 0);
    step(0, 0, 0, 1, 32'h32, 0, 0);
    step(0, 0, 0, 1, 32'h34, 0, 0);
    step(0, 0, 1, 1, 32'h33, 0, 0);
    idle(8);
    chk("flush_no_output", 32'(emitted - em0), 32'd0);

    // Reset while stalled with items in flight
    load(5'd5);
    em0 = emitted;
    step(0, 0, 0, 1, 32'h51, 0, 0);
    step(0, 0, 0, 1, 32'h52, 0, 0);
    step(0, 1, 0, 0, $urandom, 0, 0);
    step(1, 1, 0, 0, $urandom, 1, 5'd2);
    idle(1);
    chk("rst_dly_cur", {27'b0, dly_cur}, 32'd16);
    idle(20);
    chk("rst_no_stale", 32'(emitted - em0), 32'd0);

    // Random traffic with periodic drain windows for reconfiguration
    for (int i = 0; i < 2500; i++) begin
      bit gap;
      gap = (i % 160) >= 120;
      v  = !gap && ($urandom_range(0, 2) != 0);
      s  = ($urandom_range(0, 7) == 0);
      f  = ($urandom_range(0, 60) == 0);
      ld = gap ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 40) == 0);
      r  = ($urandom_range(0, 400) == 0);
      if (r) s = 1'b1;
      step(r, s, f, v, $urandom, ld, 5'($urandom_range(0, 20)));
    end
    idle(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
